// File: rtl/wb_window_tracker.sv
// wb_window_tracker
//   Pairs EX-phase trace records with timestamped writeback events and
//   emits one WB window per record.
//
//   Records are buffered in a record FIFO. Every wb_ready pulse is stamped
//   with the cycle counter and the rvalid activity since the previous pulse,
//   then buffered in an event FIFO. Records and events are consumed in order.
//
//   Ports
//     clk, rst            : clock (rising edge), async active-low reset
//     counter             : free-running cycle counter
//     ex_*                : record input, ready/valid handshake
//     wb_ready            : WB completion pulse (one per tracked record)
//     data_mem_rvalid     : memory response activity
//     wb_valid/wb_accept  : output handshake
//     wb_tag, wb_time_*,
//     wb_res_*, wb_timeout: output record
//     evt_overflow        : sticky, an event was dropped on a full event FIFO
//     previous_end_o      : end time of the last emitted tracked record
//
//   state      | meaning
//   S_IDLE     | pop next record; pass-through goes straight to S_EMIT
//   S_WAIT_EVT | wait for a WB event, or force an emit on timeout
//   S_EMIT     | hold the output record until wb_accept
module wb_window_tracker #(
    parameter int CNT_W     = 32,
    parameter int TAG_W     = 8,
    parameter int REC_DEPTH = 8,
    parameter int EVT_DEPTH = 8,
    parameter int TIMEOUT   = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] counter,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [TAG_W-1:0] ex_tag,
    input  logic [CNT_W-1:0] ex_time_end,
    input  logic             ex_pass_through,
    input  logic             ex_is_load,
    input  logic             wb_ready,
    input  logic             data_mem_rvalid,
    output logic             wb_valid,
    input  logic             wb_accept,
    output logic [TAG_W-1:0] wb_tag,
    output logic [CNT_W-1:0] wb_time_start,
    output logic [CNT_W-1:0] wb_time_end,
    output logic [CNT_W-1:0] wb_res_start,
    output logic [CNT_W-1:0] wb_res_end,
    output logic             wb_timeout,
    output logic             evt_overflow,
    output logic [CNT_W-1:0] previous_end_o
);

    localparam int REC_AW = $clog2(REC_DEPTH);
    localparam int EVT_AW = $clog2(EVT_DEPTH);
    localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_EVT, S_EMIT} state_t;

    // a is strictly later than b, judged by the signed modular distance
    function automatic logic is_after(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        logic [CNT_W-1:0] d;
        d = a - b;
        return !d[CNT_W-1] && (d != '0);
    endfunction

    state_t state, state_nxt;

    // ---------------- record FIFO ----------------
    logic [TAG_W-1:0] rec_tag_mem [REC_DEPTH];
    logic [CNT_W-1:0] rec_te_mem  [REC_DEPTH];
    logic             rec_pt_mem  [REC_DEPTH];
    logic             rec_ld_mem  [REC_DEPTH];
    logic [REC_AW:0]  rec_wr, rec_rd;
    logic             rec_full, rec_empty, rec_push, rec_pop;

    assign rec_empty = (rec_wr == rec_rd);
    assign rec_full  = (rec_wr[REC_AW] != rec_rd[REC_AW]) &&
                       (rec_wr[REC_AW-1:0] == rec_rd[REC_AW-1:0]);
    assign ex_ready  = !rec_full;
    assign rec_push  = ex_valid && !rec_full;

    always_ff @(posedge clk) begin
        if (rec_push) begin
            rec_tag_mem[rec_wr[REC_AW-1:0]] <= ex_tag;
            rec_te_mem[rec_wr[REC_AW-1:0]]  <= ex_time_end;
            rec_pt_mem[rec_wr[REC_AW-1:0]]  <= ex_pass_through;
            rec_ld_mem[rec_wr[REC_AW-1:0]]  <= ex_is_load;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rec_wr <= '0;
            rec_rd <= '0;
        end else begin
            if (rec_push) rec_wr <= rec_wr + 1'b1;
            if (rec_pop)  rec_rd <= rec_rd + 1'b1;
        end
    end

    // ---------------- rvalid accumulator and event FIFO ----------------
    logic             acc_has;
    logic [CNT_W-1:0] acc_first, acc_last;
    logic             mrg_has;
    logic [CNT_W-1:0] mrg_first, mrg_last;

    // current-cycle rvalid folds into an event taken on the same edge
    assign mrg_has   = acc_has | data_mem_rvalid;
    assign mrg_first = acc_has ? acc_first : counter;
    assign mrg_last  = data_mem_rvalid ? counter : acc_last;

    logic [CNT_W-1:0] evt_t_mem     [EVT_DEPTH];
    logic             evt_has_mem   [EVT_DEPTH];
    logic [CNT_W-1:0] evt_first_mem [EVT_DEPTH];
    logic [CNT_W-1:0] evt_last_mem  [EVT_DEPTH];
    logic [EVT_AW:0]  evt_wr, evt_rd;
    logic             evt_full, evt_empty, evt_push, evt_pop;

    assign evt_empty = (evt_wr == evt_rd);
    assign evt_full  = (evt_wr[EVT_AW] != evt_rd[EVT_AW]) &&
                       (evt_wr[EVT_AW-1:0] == evt_rd[EVT_AW-1:0]);
    // a pop on the same edge frees the slot, so a full FIFO still accepts
    assign evt_push  = wb_ready && (!evt_full || evt_pop);

    always_ff @(posedge clk) begin
        if (evt_push) begin
            evt_t_mem[evt_wr[EVT_AW-1:0]]     <= counter;
            evt_has_mem[evt_wr[EVT_AW-1:0]]   <= mrg_has;
            evt_first_mem[evt_wr[EVT_AW-1:0]] <= mrg_first;
            evt_last_mem[evt_wr[EVT_AW-1:0]]  <= mrg_last;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt_wr       <= '0;
            evt_rd       <= '0;
            acc_has      <= 1'b0;
            acc_first    <= '0;
            acc_last     <= '0;
            evt_overflow <= 1'b0;
        end else begin
            if (evt_push) evt_wr <= evt_wr + 1'b1;
            if (evt_pop)  evt_rd <= evt_rd + 1'b1;
            if (wb_ready && evt_full && !evt_pop) evt_overflow <= 1'b1;
            if (wb_ready) begin
                acc_has <= 1'b0;
            end else if (data_mem_rvalid) begin
                acc_has  <= 1'b1;
                acc_last <= counter;
                if (!acc_has) acc_first <= counter;
            end
        end
    end

    // ---------------- window arithmetic ----------------
    logic [TAG_W-1:0] cur_tag;
    logic [CNT_W-1:0] cur_te;
    logic             cur_ld;
    logic [CNT_W-1:0] previous_end;
    logic [CNT_W-1:0] cand_ex, cand_prev, start_max, win_end, start_win;
    logic [CNT_W-1:0] evt_t_head;

    assign evt_t_head = evt_t_mem[evt_rd[EVT_AW-1:0]];
    assign cand_ex    = cur_te + CNT_W'(1);
    assign cand_prev  = previous_end + CNT_W'(1);
    assign start_max  = is_after(cand_ex, cand_prev) ? cand_ex : cand_prev;
    // window end is the event time, or now when the wait times out
    assign win_end    = evt_empty ? counter : evt_t_head;
    assign start_win  = is_after(start_max, win_end) ? win_end : start_max;

    // ---------------- FSM ----------------
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_load, tmo_dec, ld_pass, ld_evt, ld_tmo, clr_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rec_pop   = 1'b0;
        evt_pop   = 1'b0;
        tmo_load  = 1'b0;
        tmo_dec   = 1'b0;
        ld_pass   = 1'b0;
        ld_evt    = 1'b0;
        ld_tmo    = 1'b0;
        clr_out   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rec_empty) begin
                    rec_pop = 1'b1;
                    if (rec_pt_mem[rec_rd[REC_AW-1:0]]) begin
                        ld_pass   = 1'b1;
                        state_nxt = S_EMIT;
                    end else begin
                        tmo_load  = 1'b1;
                        state_nxt = S_WAIT_EVT;
                    end
                end
            end
            S_WAIT_EVT: begin
                if (!evt_empty) begin
                    evt_pop   = 1'b1;
                    ld_evt    = 1'b1;
                    state_nxt = S_EMIT;
                end else if (tmo_cnt == '0) begin
                    ld_tmo    = 1'b1;
                    state_nxt = S_EMIT;
                end else begin
                    tmo_dec = 1'b1;
                end
            end
            S_EMIT: begin
                if (wb_accept) begin
                    clr_out   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt        <= '0;
            cur_tag        <= '0;
            cur_te         <= '0;
            cur_ld         <= 1'b0;
            previous_end   <= '0;
            previous_end_o <= '0;
            wb_valid       <= 1'b0;
            wb_timeout     <= 1'b0;
            wb_tag         <= '0;
            wb_time_start  <= '0;
            wb_time_end    <= '0;
            wb_res_start   <= '0;
            wb_res_end     <= '0;
        end else begin
            previous_end_o <= previous_end;
            if (tmo_load) tmo_cnt <= TMO_LOAD;
            if (tmo_dec)  tmo_cnt <= tmo_cnt - 1'b1;
            if (rec_pop) begin
                cur_tag <= rec_tag_mem[rec_rd[REC_AW-1:0]];
                cur_te  <= rec_te_mem[rec_rd[REC_AW-1:0]];
                cur_ld  <= rec_ld_mem[rec_rd[REC_AW-1:0]];
            end
            if (ld_pass) begin
                wb_tag        <= rec_tag_mem[rec_rd[REC_AW-1:0]];
                wb_time_start <= '0;
                wb_time_end   <= '0;
                wb_res_start  <= '0;
                wb_res_end    <= '0;
                wb_timeout    <= 1'b0;
                wb_valid      <= 1'b1;
            end
            if (ld_evt) begin
                wb_tag        <= cur_tag;
                wb_time_start <= start_win;
                wb_time_end   <= evt_t_head;
                if (cur_ld && evt_has_mem[evt_rd[EVT_AW-1:0]]) begin
                    wb_res_start <= evt_first_mem[evt_rd[EVT_AW-1:0]];
                    wb_res_end   <= evt_last_mem[evt_rd[EVT_AW-1:0]];
                end else begin
                    wb_res_start <= '0;
                    wb_res_end   <= '0;
                end
                previous_end  <= evt_t_head;
                wb_valid      <= 1'b1;
            end
            if (ld_tmo) begin
                wb_tag        <= cur_tag;
                wb_time_start <= start_win;
                wb_time_end   <= counter;
                wb_res_start  <= '0;
                wb_res_end    <= '0;
                wb_timeout    <= 1'b1;
                wb_valid      <= 1'b1;
            end
            if (clr_out) begin
                wb_valid   <= 1'b0;
                wb_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_window_tracker.sv
module tb_wb_window_tracker;

    localparam int CNT_W = 8;
    localparam int TAG_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [CNT_W-1:0] counter = '0;
    logic             ex_valid = 1'b0;
    logic             ex_ready;
    logic [TAG_W-1:0] ex_tag = '0;
    logic [CNT_W-1:0] ex_time_end = '0;
    logic             ex_pass_through = 1'b0;
    logic             ex_is_load = 1'b0;
    logic             wb_ready = 1'b0;
    logic             data_mem_rvalid = 1'b0;
    logic             wb_valid;
    logic             wb_accept = 1'b1;
    logic [TAG_W-1:0] wb_tag;
    logic [CNT_W-1:0] wb_time_start, wb_time_end, wb_res_start, wb_res_end;
    logic             wb_timeout;
    logic             evt_overflow;
    logic [CNT_W-1:0] previous_end_o;

    wb_window_tracker #(
        .CNT_W(CNT_W), .TAG_W(TAG_W), .REC_DEPTH(8), .EVT_DEPTH(8), .TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst), .counter(counter),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_tag(ex_tag),
        .ex_time_end(ex_time_end), .ex_pass_through(ex_pass_through),
        .ex_is_load(ex_is_load), .wb_ready(wb_ready),
        .data_mem_rvalid(data_mem_rvalid), .wb_valid(wb_valid),
        .wb_accept(wb_accept), .wb_tag(wb_tag),
        .wb_time_start(wb_time_start), .wb_time_end(wb_time_end),
        .wb_res_start(wb_res_start), .wb_res_end(wb_res_end),
        .wb_timeout(wb_timeout), .evt_overflow(evt_overflow),
        .previous_end_o(previous_end_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] tag;
        logic [7:0] ts;
        logic [7:0] te;
        logic [7:0] rs;
        logic [7:0] re;
        logic       tmo;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] tg, input logic [7:0] ts, input logic [7:0] te,
                                input logic [7:0] rs, input logic [7:0] re, input logic tmo);
        exp_t e;
        e.tag = tg; e.ts = ts; e.te = te; e.rs = rs; e.re = re; e.tmo = tmo;
        return e;
    endfunction

    // counter advances by one per edge; the value seen at the next edge is
    // whatever counter holds when inputs are driven
    task automatic tick();
        @(posedge clk);
        #1;
        counter = counter + 8'd1;
    endtask

    task automatic cyc(input logic ev, input logic [7:0] tg, input logic [7:0] te,
                       input logic pt, input logic ld, input logic wbr, input logic rv);
        ex_valid        = ev;
        ex_tag          = tg;
        ex_time_end     = te;
        ex_pass_through = pt;
        ex_is_load      = ld;
        wb_ready        = wbr;
        data_mem_rvalid = rv;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // tracked record: pushed at wbr_t-2, wb_ready at wbr_t
    // rv_mask bits: rvalid at push cycle, middle cycle, wb_ready cycle
    task automatic do_rec(input logic [7:0] tg, input logic [7:0] te, input logic ld,
                          input logic [7:0] wbr_t, input logic [2:0] rv_mask,
                          input logic [7:0] ets, input logic [7:0] ers, input logic [7:0] ere);
        counter = wbr_t - 8'd2;
        chk("rec_ready", ex_ready, 1);
        sb_q.push_back(mk(tg, ets, wbr_t, ers, ere, 1'b0));
        cyc(1'b1, tg, te, 1'b0, ld, 1'b0, rv_mask[0]);
        cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, rv_mask[1]);
        cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, rv_mask[2]);
        idle(3);
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (rst && wb_valid && wb_accept) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_tag", 64'(wb_tag), 64'h100);
            end else begin
                mon_e = sb_q.pop_front();
                chk("wb_tag", wb_tag, mon_e.tag);
                chk("wb_time_start", wb_time_start, mon_e.ts);
                chk("wb_time_end", wb_time_end, mon_e.te);
                chk("wb_res_start", wb_res_start, mon_e.rs);
                chk("wb_res_end", wb_res_end, mon_e.re);
                chk("wb_timeout", wb_timeout, mon_e.tmo);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         idx;
        logic       rdy;
        logic [7:0] tg;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_ex_ready", ex_ready, 1);
        chk("rst_overflow", evt_overflow, 0);
        chk("rst_prev_end", previous_end_o, 0);
        chk("rst_wb_tag", wb_tag, 0);
        chk("rst_time_start", wb_time_start, 0);
        chk("rst_timeout", wb_timeout, 0);
        rst = 1'b1;
        idle(2);

        // pass-through: one-cycle valid, all times 0
        sb_q.push_back(mk(8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
        cyc(1'b1, 8'h11, 8'd77, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("pt_valid_hi", wb_valid, 1);
        idle(1);
        chk("pt_valid_lo", wb_valid, 0);
        idle(2);
        chk("pt_prev_end", previous_end_o, 0);

        // load with response window
        do_rec(8'h22, 8'd100, 1'b1, 8'd105, 3'b011, 8'd101, 8'd103, 8'd104);
        chk("load_prev_end", previous_end_o, 105);

        // non-load with stray rvalid, then clamp
        do_rec(8'h33, 8'd200, 1'b0, 8'd203, 3'b100, 8'd201, 8'd0, 8'd0);
        do_rec(8'h44, 8'd150, 1'b0, 8'd203, 3'b000, 8'd203, 8'd0, 8'd0);
        chk("clamp_prev_end", previous_end_o, 203);

        // walk previous_end forward, then wrap the counter
        do_rec(8'h71, 8'd100, 1'b0, 8'd120, 3'b000, 8'd120, 8'd0, 8'd0);
        do_rec(8'h72, 8'd200, 1'b0, 8'd220, 3'b000, 8'd201, 8'd0, 8'd0);
        do_rec(8'h73, 8'd254, 1'b0, 8'd2,   3'b000, 8'd255, 8'd0, 8'd0);
        chk("wrap_prev_end", previous_end_o, 2);

        // backpressure: 1 record held in the output stage + 8 in the FIFO
        wb_accept = 1'b0;
        idx = 0;
        for (int i = 0; i < 15; i++) begin
            tg  = 8'hA0 + 8'(idx);
            rdy = ex_ready;
            if (rdy) sb_q.push_back(mk(tg, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
            cyc(1'b1, tg, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
            if (rdy) idx++;
        end
        chk("bp_stored", idx, 9);
        chk("bp_ex_ready", ex_ready, 0);
        chk("bp_hold_tag", wb_tag, 8'hA0);
        wb_accept = 1'b1;
        for (int i = 0; i < 40 && idx < 10; i++) begin
            tg  = 8'hA0 + 8'(idx);
            rdy = ex_ready;
            if (rdy) sb_q.push_back(mk(tg, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
            cyc(1'b1, tg, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
            if (rdy) idx++;
        end
        idle(30);
        chk("bp_pushed", idx, 10);
        chk("bp_drain", sb_q.size(), 0);
        chk("bp_prev_end", previous_end_o, 2);

        // event overflow: 9 pulses at counters 10..18, the last one dropped
        counter = 8'd10;
        repeat (9) cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        chk("ovf_flag", evt_overflow, 1);
        for (int i = 0; i < 8; i++) begin
            for (int w = 0; w < 20 && !ex_ready; w++) idle(1);
            if (!ex_ready) chk("ovf_ready_wait", ex_ready, 1);
            sb_q.push_back(mk(8'hB0 + 8'(i), (i == 0) ? 8'd8 : 8'(10 + i), 8'(10 + i),
                              8'h00, 8'h00, 1'b0));
            cyc(1'b1, 8'hB0 + 8'(i), 8'(7 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        idle(30);
        chk("ovf_drain", sb_q.size(), 0);
        chk("ovf_prev_end", previous_end_o, 17);

        // timeout: pushed at 50, popped at 51, fires on the 4th WAIT edge (55)
        counter = 8'd50;
        sb_q.push_back(mk(8'hC1, 8'd46, 8'd55, 8'h00, 8'h00, 1'b1));
        cyc(1'b1, 8'hC1, 8'd45, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(8);
        chk("tmo_drain", sb_q.size(), 0);
        chk("tmo_prev_end", previous_end_o, 17);

        // reset while a record is held in the output stage
        wb_accept = 1'b0;
        cyc(1'b1, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        chk("rst_pre_valid", wb_valid, 1);
        rst = 1'b0;
        #1;
        chk("rst_mid_valid", wb_valid, 0);
        chk("rst_mid_overflow", evt_overflow, 0);
        chk("rst_mid_prev_end", previous_end_o, 0);
        chk("rst_mid_ex_ready", ex_ready, 1);
        chk("rst_mid_tag", wb_tag, 0);
        sb_q.delete();
        idle(2);
        rst = 1'b1;
        wb_accept = 1'b1;
        idle(1);
        sb_q.push_back(mk(8'h66, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
        cyc(1'b1, 8'h66, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(6);
        chk("post_rst_drain", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
